argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of class scores scanned (minimum 1).
REQ-002 Parameter SCORE_W, default 32, width of each class score in bits.
REQ-003 Parameter IDX_W, default 4, width of the class index (at least clog2(NUM_CLASSES), and at least 1).
REQ-004 Parameter SIGNED_MODE, default 1: 1 compares scores as two's complement; 0 compares them as unsigned.
REQ-005 Port clk_clk, input, 1, sole clock; all logic is rising-edge.
REQ-006 Port reset_reset, input, 1, asynchronous active-high reset.
REQ-007 Port start, input, 1, request to classify the current scores.
REQ-008 Port scores, input, NUM_CLASSES*SCORE_W, flattened scores; class k occupies bits [k*SCORE_W +: SCORE_W].
REQ-009 Port min_margin, input, SCORE_W, unsigned confidence threshold.
REQ-010 Port busy, output, 1, high while a classification is in progress.
REQ-011 Port done, output, 1, one-cycle pulse marking that the results are updated.
REQ-012 Port inference, output, IDX_W, index of the winning class.
REQ-013 Port best_score, output, SCORE_W, score of the winning class.
REQ-014 Port margin, output, SCORE_W, unsigned difference top1 - top2.
REQ-015 Port tie, output, 1, high when at least two classes share the top score.
REQ-016 Port confident, output, 1, high when margin >= min_margin and tie = 0.

Function
REQ-017 FSM states: IDLE, SCAN, DONE; the state is registered.
REQ-018 IDLE with start = 1 at edge E0: snapshot scores and min_margin into internal registers, clear the class counter, set busy, enter SCAN.
REQ-019 SCAN processes one class per edge; class k is processed at edge E(k+1), using the snapshot only, so scores may change freely after E0.
REQ-020 Class 0 loads top1 = s0, top2 = the minimum representable value (signed: -2^(SCORE_W-1); unsigned: 0), and idx = 0.
REQ-021 Class k > 0 update: if s > top1, then top2 <- top1, top1 <- s, idx <- k; else if s > top2, then top2 <- s; otherwise there is no change.
REQ-022 Comparison is strictly greater-than, so among equal top scores the lowest index wins.
REQ-023 After class NUM_CLASSES-1, at edge E(NUM_CLASSES), the FSM enters DONE.
REQ-024 DONE, at edge E(NUM_CLASSES+1): register all results, pulse done high for exactly one cycle, clear busy, return to IDLE.
REQ-025 For NUM_CLASSES = 10, done is high in the cycle following edge E11; start-to-done latency is NUM_CLASSES + 1 edges.
REQ-026 margin = top1 - top2, computed as a SCORE_W-bit unsigned value; because top1 >= top2 always holds, no overflow is possible.
REQ-027 tie = 1 if and only if margin = 0 and NUM_CLASSES >= 2.
REQ-028 confident is registered together with the other results and uses the snapshot of min_margin.
REQ-029 inference, best_score, margin, tie and confident hold their values between done pulses.
REQ-030 start is ignored while busy = 1, including in the DONE cycle; there is no queuing.
REQ-031 start held high continuously: a new classification begins on the first IDLE edge after each done, a period of NUM_CLASSES + 2 edges.
REQ-032 NUM_CLASSES = 1: inference = 0, best_score = s0, margin = s0 - min, tie = 0.

Reset
REQ-033 Asserting reset_reset at any time, including mid-SCAN, forces the FSM to IDLE immediately, without waiting for a clock edge.
REQ-034 Reset values: busy = 0, done = 0, inference = 0, best_score = 0, margin = 0, tie = 0, confident = 0; internal counter and top registers are cleared.
REQ-035 An interrupted classification produces no done pulse; the first start after reset release begins a fresh scan.

Verification
REQ-036 Defaults, signed: scores = {0:5, 1:-3, 2:40, 3:7, 4:12, 5:0, 6:-100, 7:39, 8:1, 9:2}, min_margin = 0 -> done at E11, inference = 2, best_score = 40, margin = 1, tie = 0, confident = 1.
REQ-037 Tie case: class 3 = class 8 = 50, all other classes = 10 -> inference = 3, margin = 0, tie = 1, confident = 0.
REQ-038 SIGNED_MODE = 0: class 4 = 0xFFFFFFFF, all others = 1 -> inference = 4, margin = 0xFFFFFFFE; with SIGNED_MODE = 1, the same stimulus gives inference = 0 and tie = 1.
REQ-039 Snapshot/busy: change the scores at E1 and pulse start at E5 -> the results reflect the E0 scores, exactly one done pulse, busy high from E0 through E11.
REQ-040 Reset at E6 mid-scan -> all outputs become 0 asynchronously with no done pulse; start at E10 -> done at E21 with the correct result.
REQ-041 Confidence threshold: margin = 1, min_margin = 2 -> confident = 0; min_margin = 1 -> confident = 1.

Source files
------------

// File: rtl/argmax_classifier.sv
// Sequential argmax over NUM_CLASSES snapshotted scores: one class per edge, results after NUM_CLASSES+1 edges.
// Tracks top1/top2 to report the winning index, its score, the top1-top2 margin, ties and a confidence flag.
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32,
  parameter int IDX_W       = 4,
  parameter bit SIGNED_MODE = 1'b1
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset,
  input  logic                           start,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
  input  logic [SCORE_W-1:0]             min_margin,
  output logic                           busy,
  output logic                           done,
  output logic [IDX_W-1:0]               inference,
  output logic [SCORE_W-1:0]             best_score,
  output logic [SCORE_W-1:0]             margin,
  output logic                           tie,
  output logic                           confident
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [SCORE_W-1:0] MIN_VAL =
    SIGNED_MODE ? {1'b1, {(SCORE_W-1){1'b0}}} : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                         state_q, state_d;
  logic [NUM_CLASSES*SCORE_W-1:0] snap_q, snap_d;
  logic [SCORE_W-1:0]             min_margin_q, min_margin_d;
  logic [IDX_W-1:0]               cnt_q, cnt_d;
  logic [SCORE_W-1:0]             top1_q, top1_d;
  logic [SCORE_W-1:0]             top2_q, top2_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           done_q, done_d;
  logic [IDX_W-1:0]               inference_q, inference_d;
  logic [SCORE_W-1:0]             best_q, best_d;
  logic [SCORE_W-1:0]             margin_q, margin_d;
  logic                           tie_q, tie_d;
  logic                           conf_q, conf_d;
  logic [SCORE_W-1:0]             s_cur;
  logic [SCORE_W-1:0]             diff;

  function automatic logic gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    if (SIGNED_MODE) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  always_comb begin
    s_cur = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (cnt_q == IDX_W'(k)) s_cur = snap_q[k*SCORE_W +: SCORE_W];
    end
  end

  // top1 >= top2 is invariant, so this never wraps.
  assign diff = top1_q - top2_q;

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    min_margin_d = min_margin_q;
    cnt_d        = cnt_q;
    top1_d       = top1_q;
    top2_d       = top2_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    inference_d  = inference_q;
    best_d       = best_q;
    margin_d     = margin_q;
    tie_d        = tie_q;
    conf_d       = conf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d       = scores;
          min_margin_d = min_margin;
          cnt_d        = '0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == '0) begin
          top1_d = s_cur;
          top2_d = MIN_VAL;
          idx_d  = '0;
        end else if (gt(s_cur, top1_q)) begin
          top2_d = top1_q;
          top1_d = s_cur;
          idx_d  = cnt_q;
        end else if (gt(s_cur, top2_q)) begin
          top2_d = s_cur;
        end
        if (cnt_q == LAST_IDX) state_d = DONE;
        else                   cnt_d   = cnt_q + IDX_W'(1);
      end
      DONE: begin
        done_d      = 1'b1;
        inference_d = idx_q;
        best_d      = top1_q;
        margin_d    = diff;
        tie_d       = (NUM_CLASSES >= 2) && (diff == '0);
        conf_d      = (diff >= min_margin_q) && !((NUM_CLASSES >= 2) && (diff == '0));
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      min_margin_q <= '0;
      cnt_q        <= '0;
      top1_q       <= '0;
      top2_q       <= '0;
      idx_q        <= '0;
      done_q       <= 1'b0;
      inference_q  <= '0;
      best_q       <= '0;
      margin_q     <= '0;
      tie_q        <= 1'b0;
      conf_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      min_margin_q <= min_margin_d;
      cnt_q        <= cnt_d;
      top1_q       <= top1_d;
      top2_q       <= top2_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
      inference_q  <= inference_d;
      best_q       <= best_d;
      margin_q     <= margin_d;
      tie_q        <= tie_d;
      conf_q       <= conf_d;
    end
  end

  // busy spans E0 through the DONE edge; derived from state so reset clears it at once.
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign inference  = inference_q;
  assign best_score = best_q;
  assign margin     = margin_q;
  assign tie        = tie_q;
  assign confident  = conf_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Randomized scoreboard bench: a signed and an unsigned instance share stimulus; a sort-style
// reference model predicts each result and its due cycle, and per-instance monitors compare on done.
module tb_argmax_classifier;
  localparam int N = 10;
  localparam int W = 32;

  typedef logic [W-1:0] sarr_t [N];
  typedef struct {
    logic [3:0]   idx;
    logic [W-1:0] best;
    logic [W-1:0] marg;
    logic         tie;
    logic         conf;
    longint       due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N*W-1:0] scores = '0;
  logic [W-1:0]   mm = '0;

  logic busy_s, done_s, tie_s, conf_s, busy_u, done_u, tie_u, conf_u;
  logic [3:0]   inf_s, inf_u;
  logic [W-1:0] best_s, best_u, marg_s, marg_u;

  argmax_classifier #(.NUM_CLASSES(N), .SCORE_W(W), .IDX_W(4), .SIGNED_MODE(1'b1)) dut_s (
    .clk_clk(clk), .reset_reset(rst), .start(start), .scores(scores), .min_margin(mm),
    .busy(busy_s), .done(done_s), .inference(inf_s), .best_score(best_s), .margin(marg_s),
    .tie(tie_s), .confident(conf_s));

  argmax_classifier #(.NUM_CLASSES(N), .SCORE_W(W), .IDX_W(4), .SIGNED_MODE(1'b0)) dut_u (
    .clk_clk(clk), .reset_reset(rst), .start(start), .scores(scores), .min_margin(mm),
    .busy(busy_u), .done(done_u), .inference(inf_u), .best_score(best_u), .margin(marg_u),
    .tie(tie_u), .confident(conf_u));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q_s[$];
  exp_t q_u[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Winner = first index holding the maximum; runner-up = best of the remaining classes.
  function automatic exp_t model(input sarr_t s, input logic [W-1:0] m, input bit sgn);
    exp_t   e;
    longint v [N];
    longint t1, t2;
    int     idx;
    for (int k = 0; k < N; k++) v[k] = sgn ? longint'($signed(s[k])) : longint'(s[k]);
    idx = 0;
    t1  = v[0];
    for (int k = 1; k < N; k++) if (v[k] > t1) begin t1 = v[k]; idx = k; end
    t2 = sgn ? -(longint'(1) << (W-1)) : 0;
    for (int k = 0; k < N; k++) if (k != idx && v[k] > t2) t2 = v[k];
    e.idx  = 4'(idx);
    e.best = s[idx];
    e.marg = W'(t1 - t2);
    e.tie  = (t1 == t2);
    e.conf = (e.marg >= m) && !e.tie;
    e.due  = 0;
    return e;
  endfunction

  function automatic sarr_t rand_scores(input int mode);
    sarr_t s;
    logic [W-1:0] pool [5];
    pool = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h1, 32'hFFFF_FFFF};
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       s[k] = $urandom;
        1:       s[k] = W'($urandom_range(0, 15)) - 32'd8;
        default: s[k] = pool[$urandom_range(0, 4)];
      endcase
    end
    return s;
  endfunction

  always @(negedge clk) begin : mon_s
    exp_t e;
    if (!rst && done_s) begin
      if (q_s.size() == 0) begin
        n_chk++;
        $display("FAIL s_spurious_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = q_s.pop_front();
        chk("s_done_cycle", 64'(cyc), 64'(e.due));
        chk("s_inference", 64'(inf_s), 64'(e.idx));
        chk("s_best", 64'(best_s), 64'(e.best));
        chk("s_margin", 64'(marg_s), 64'(e.marg));
        chk("s_tie", 64'(tie_s), 64'(e.tie));
        chk("s_confident", 64'(conf_s), 64'(e.conf));
      end
    end
  end

  always @(negedge clk) begin : mon_u
    exp_t e;
    if (!rst && done_u) begin
      if (q_u.size() == 0) begin
        n_chk++;
        $display("FAIL u_spurious_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = q_u.pop_front();
        chk("u_done_cycle", 64'(cyc), 64'(e.due));
        chk("u_inference", 64'(inf_u), 64'(e.idx));
        chk("u_best", 64'(best_u), 64'(e.best));
        chk("u_margin", 64'(marg_u), 64'(e.marg));
        chk("u_tie", 64'(tie_u), 64'(e.tie));
        chk("u_confident", 64'(conf_u), 64'(e.conf));
      end
    end
  end

  task automatic drive(input sarr_t s, input logic [W-1:0] m);
    for (int k = 0; k < N; k++) scores[k*W +: W] = s[k];
    mm = m;
  endtask

  task automatic push_exp(input sarr_t s, input logic [W-1:0] m, input longint due);
    exp_t e;
    e = model(s, m, 1'b1); e.due = due; q_s.push_back(e);
    e = model(s, m, 1'b0); e.due = due; q_u.push_back(e);
  endtask

  // Called at a negedge. perturb: scramble inputs after E0 and re-pulse start at E5.
  task automatic classify(input sarr_t s, input logic [W-1:0] m, input bit perturb);
    int bc;
    bc = 0;
    while (busy_s && bc < 200) begin @(negedge clk); bc++; end
    if (busy_s) chk("idle_wait_timeout", 64'(busy_s), 64'(0));
    drive(s, m);
    start = 1'b1;
    push_exp(s, m, cyc + 12);
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    while (busy_s && bc < 200) begin
      bc++;
      if (perturb && bc == 1) drive(rand_scores(0), $urandom);
      if (perturb && bc == 5) start = 1'b1;
      if (perturb && bc == 6) start = 1'b0;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(bc), 64'(N + 1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy_s"}, 64'(busy_s), 64'(0));
    chk({tag, "_done_s"}, 64'(done_s), 64'(0));
    chk({tag, "_inf_s"}, 64'(inf_s), 64'(0));
    chk({tag, "_best_s"}, 64'(best_s), 64'(0));
    chk({tag, "_margin_s"}, 64'(marg_s), 64'(0));
    chk({tag, "_tie_s"}, 64'(tie_s), 64'(0));
    chk({tag, "_conf_s"}, 64'(conf_s), 64'(0));
    chk({tag, "_busy_u"}, 64'(busy_u), 64'(0));
    chk({tag, "_inf_u"}, 64'(inf_u), 64'(0));
    chk({tag, "_margin_u"}, 64'(marg_u), 64'(0));
  endtask

  initial begin
    sarr_t  s;
    longint c;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    s = '{32'd5, -32'sd3, 32'd40, 32'd7, 32'd12, 32'd0, -32'sd100, 32'd39, 32'd1, 32'd2};
    classify(s, 32'd0, 1'b0);
    s = '{default: 32'd10};
    s[3] = 32'd50; s[8] = 32'd50;
    classify(s, 32'd0, 1'b0);
    s = '{default: 32'd1};
    s[4] = 32'hFFFF_FFFF;
    classify(s, 32'd0, 1'b0);
    s = '{default: 32'd0};
    s[0] = 32'd10; s[1] = 32'd9;
    classify(s, 32'd2, 1'b0);
    classify(s, 32'd1, 1'b0);
    classify(rand_scores(0), $urandom, 1'b1);
    for (int i = 0; i < 24; i++)
      classify(rand_scores(i % 3), W'($urandom_range(0, 3)), 1'b0);

    // Interrupted scan: reset asserted shortly after E6 must clear outputs immediately.
    drive(rand_scores(1), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midscan_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    classify(rand_scores(1), 32'd1, 1'b0);

    // start held high: back-to-back runs every N+2 edges.
    s = rand_scores(0);
    drive(s, 32'd0);
    start = 1'b1;
    c = cyc;
    push_exp(s, 32'd0, c + 12);
    push_exp(s, 32'd0, c + 24);
    push_exp(s, 32'd0, c + 36);
    repeat (25) @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);

    chk("s_results_outstanding", 64'(q_s.size()), 64'(0));
    chk("u_results_outstanding", 64'(q_u.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
